// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer: adds two WIDTH-bit operands two bits per clock through
// one shared 2-bit carry-lookahead slice (cla_adder), least-significant slice
// first. Optional subtract mode is enabled by defining CLA_SEQ_SUBTRACT_EN.
//
// Handshake: START is sampled only while the controller is idle. The edge
// that samples START=1 captures A, B and CIN (and SUB). START is ignored while
// BUSY is high, and requests are not queued. DONE is a one-cycle pulse that
// marks SUM/COUT as valid. SUM/COUT then hold until the next DONE or reset.

// 2-bit carry-lookahead slice: generate/propagate with both carries computed
// directly from cin, so neither carry ripples through the other.
module cla_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);
  logic [1:0] g;
  logic [1:0] p;
  logic       c1;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c1   = g[0] | (p[0] & cin);
  assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign sum  = {p[1] ^ c1, p[0] ^ cin};
endmodule

module cla_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef CLA_SEQ_SUBTRACT_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic [1:0]       dbg_state
);
  localparam int BEATS = WIDTH / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] s_next;

  assign dbg_state = state;

  // Operand conditioning at capture: subtract is A + ~B + ~CIN, so that
  // COUT reads as not-borrow. Without the option no inversion exists.
`ifdef CLA_SEQ_SUBTRACT_EN
  assign b_in   = SUB ? ~B : B;
  assign cin_in = SUB ^ CIN;
`else
  assign b_in   = B;
  assign cin_in = CIN;
`endif

  cla_adder u_slice (
    .a    (a_sh[1:0]),
    .b    (b_sh[1:0]),
    .cin  (c_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result shift register after this beat: new slice bits enter at the top.
  always_comb begin
    s_next              = s_sh >> 2;
    s_next[WIDTH-1 -: 2] = slice_sum;
  end

  // Controller FSM with registered BUSY/DONE/SUM/COUT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
      cnt   <= '0;
      c_r   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sh  <= A;
            b_sh  <= b_in;
            c_r   <= cin_in;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 2;
          b_sh <= b_sh >> 2;
          s_sh <= s_next;
          c_r  <= slice_cout;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            SUM   <= s_next;
            COUT  <= slice_cout;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/cla_add_sequencer.md
# cla_add_sequencer

Multi-cycle controller that sequences the 2-bit `cla_adder` slice to add `WIDTH`-bit operands, two bits per clock, least-significant slice first. It holds the ripple carry between beats, shifts operands through the slice and registers the full-width result. It sits between a requesting datapath (START/DONE handshake) and one shared 2-bit CLA slice, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width. Must be even and at least 2. `BEATS = WIDTH/2`.
- `CLK`  in  1  the only clock; all logic updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  request; sampled only in IDLE.
- `A`  in  WIDTH  operand A, captured on the accepting edge.
- `B`  in  WIDTH  operand B, captured on the accepting edge.
- `CIN`  in  1  carry-in, captured on the accepting edge.
- `SUB`  in  1  subtract select. Present only with `CLA_SEQ_SUBTRACT_EN`.
- `BUSY`  out  1  high whenever state ≠ IDLE.
- `DONE`  out  1  one-cycle pulse when the result is valid.
- `SUM`  out  WIDTH  registered result; holds until the next DONE.
- `COUT`  out  1  registered carry-out of the top slice; holds until the next DONE.

## Operation
- Instantiates one `cla_adder` (2-bit A/B, CIN, SUM, COUT).
- Internal registers:
  - operand shift registers `a_sh`, `b_sh`
  - carry register `c_r`
  - result shift register `s_sh`
  - beat counter `cnt` of width clog2(BEATS), minimum 1 bit
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - START=1 → latch A→`a_sh`, B→`b_sh`, CIN→`c_r`, `cnt`=0; go to RUN.
  - START=0 → stay in IDLE.
- RUN, at each edge:
  - Slice inputs: `a_sh[1:0]`, `b_sh[1:0]`, `c_r`.
  - `a_sh` and `b_sh` shift right by 2.
  - Slice SUM enters `s_sh[WIDTH-1:WIDTH-2]` while `s_sh` shifts right by 2.
  - `c_r` ← slice COUT; `cnt`++.
  - When `cnt == BEATS-1`, the same edge also does: SUM ← final `s_sh` value (including this beat), COUT ← slice COUT, go to FIN.
- FIN: DONE=1 for exactly one cycle, then go to IDLE.
- START is ignored in RUN and FIN; there is no queuing.
- Arithmetic: SUM = (A + B + CIN) mod 2^WIDTH; COUT = bit WIDTH of the same sum.
- `WIDTH=2`: BEATS=1. RUN lasts one edge, then FIN.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, `cnt`=0, `c_r`=0.
- Let e0 be the edge where START is accepted:
  - BUSY is high from after e0 until after edge e0+BEATS+1.
  - The final beat and the SUM/COUT update happen at edge e0+BEATS.
  - DONE is high between e0+BEATS and e0+BEATS+1.
- START-to-DONE latency is BEATS edges (4 for WIDTH=8).
- Throughput: one operation per BEATS+2 cycles. The earliest next accept is edge e0+BEATS+2, with START held high.
- START held continuously re-triggers at every return to IDLE.
- A, B and CIN may change freely after e0 without affecting the operation in flight.
- SUM and COUT change only at the FIN-entry edge and on reset.
- RST=1 at any edge overrides everything:
  - aborts the operation, with no DONE pulse;
  - forces the reset values, including clearing SUM/COUT;
  - START on the same edge as RST is dropped.

## Configuration
- `CLA_SEQ_SUBTRACT_EN` defined:
  - Adds the `SUB` port, captured with the operands.
  - SUB=1 latches ~B into `b_sh` and ~CIN into `c_r`, giving SUM = (A − B − CIN) mod 2^WIDTH.
  - COUT is the not-borrow flag: 1 when A ≥ B + CIN.
  - SUB=0 behaves exactly as add mode.
- Not defined: no `SUB` port, add only, and no inversion logic is synthesized.

## Test plan
- Reset, then WIDTH=8, A=0x5A, B=0x3C, CIN=0, START pulse → DONE 4 edges later, SUM=0x96, COUT=0, BUSY high for 5 cycles.
- A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 → SUM=0xFF, COUT=1, with carry propagating across all 4 beats.
- Start A=0x11, B=0x22; pulse START with A=0x77 at e0+2 → that second START is ignored; result SUM=0x33, with exactly one DONE.
- RST asserted at e0+2 mid-operation → no DONE, SUM=0, COUT=0, BUSY=0 next cycle. A new START after release completes normally.
- START held high with constant operands → DONE pulses every 6 cycles. SUM is stable between pulses.
- With `CLA_SEQ_SUBTRACT_EN`:
  - SUB=1, A=0x10, B=0x01, CIN=0 → SUM=0x0F, COUT=1.
  - SUB=1, A=0x00, B=0x01, CIN=0 → SUM=0xFF, COUT=0.
